// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and bit-timing derivation
// used by both the receiver and the transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_t;

  // Core clock cycles per bit on the line.
  function automatic int symbol_edge_time(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

  // Offset from a bit edge to its midpoint.
  function automatic int sample_time(input int clock_freq, input int baud_rate);
    return symbol_edge_time(clock_freq, baud_rate) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_buffered_if.sv
// Consumer-side port of the buffered UART receiver: FWFT data with
// valid/ready, status pulses and FIFO occupancy.
interface uart_rx_buffered_if #(
  parameter int FIFO_DEPTH = 8
);
  localparam int COUNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]         data_out;
  logic               data_out_valid;
  logic               data_out_ready;
  logic               frame_err;
  logic               overrun;
  logic [COUNT_W-1:0] fifo_count;

  modport master (
    output data_out,
    output data_out_valid,
    output frame_err,
    output overrun,
    output fifo_count,
    input  data_out_ready
  );

  modport slave (
    input  data_out,
    input  data_out_valid,
    input  frame_err,
    input  overrun,
    input  fifo_count,
    output data_out_ready
  );
endinterface

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO; head shows mem[rd_ptr] whenever
// the FIFO is non-empty. DEPTH must be a power of 2 so the pointers wrap.
module sync_fifo_fwft #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      count_q <= count_q + CNT_W'(1);
      else if (do_pop && !do_push) count_q <= count_q - CNT_W'(1);
    end
  end

  // NOTE: storage is deliberately not reset; head is only meaningful while
  // count is non-zero, and leaving mem unreset lets it map to plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign count = count_q;

endmodule

// File: rtl/uart_rx_buffered.sv
// 8N1 UART receiver: input synchroniser, mid-bit sampling FSM and a
// receive FIFO presented to the consumer through valid/ready.
module uart_rx_buffered
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 1_000_000,
  parameter int FIFO_DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic serial_in,
  uart_rx_buffered_if.master rx
);

  localparam int SYMBOL_EDGE_TIME = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
  localparam int SAMPLE_TIME      = sample_time(CLOCK_FREQ, BAUD_RATE);
  localparam int CNT_W            = $clog2(SYMBOL_EDGE_TIME);
  localparam int COUNT_W          = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]       sync_q;
  logic             rx_s;
  rx_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             frame_err_q;
  logic             overrun_q;

  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic             full_blocked;
  logic             stop_sample;
  logic             push;
  logic             mid_start;
  logic             mid_bit;

  // Both stages reset high so reset never manufactures a start edge.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], serial_in};
  end
  assign rx_s = sync_q[1];

  assign mid_start    = (cnt == CNT_W'(SAMPLE_TIME - 1));
  assign mid_bit      = (cnt == CNT_W'(SYMBOL_EDGE_TIME - 1));
  assign pop          = rx.data_out_valid && rx.data_out_ready;
  assign full_blocked = fifo_full && !pop;
  assign stop_sample  = (state == STOP) && mid_bit;
  // Push straight from the sample cycle so valid appears one cycle later.
  assign push         = stop_sample && rx_s && !full_blocked;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            cnt   <= '0;
            state <= START;
          end
        end
        START: begin
          if (mid_start) begin
            if (rx_s) begin
              state <= IDLE;
            end else begin
              cnt     <= '0;
              bit_idx <= '0;
              state   <= DATA;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (mid_bit) begin
            cnt     <= '0;
            shift   <= {rx_s, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (mid_bit) begin
            cnt <= '0;
            if (!rx_s) begin
              frame_err_q <= 1'b1;
              state       <= WAIT_IDLE;
            end else begin
              overrun_q <= full_blocked;
              state     <= IDLE;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        WAIT_IDLE: begin
          // Hold off until the line returns high so a break is not a start bit.
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [COUNT_W-1:0] fifo_count;

  sync_fifo_fwft #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(shift),
    .pop      (pop),
    .head     (rx.data_out),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .count    (fifo_count)
  );

  assign rx.data_out_valid = !fifo_empty;
  assign rx.fifo_count     = fifo_count;
  assign rx.frame_err      = frame_err_q;
  assign rx.overrun        = overrun_q;

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Directed bench for uart_rx_buffered: single frames from a vector table,
// then hand-written sequences for FIFO fill, overrun, glitch and reset cases.
`timescale 1ns/1ps
module tb_uart_rx_buffered;
  import uart_pkg::*;

  localparam int BIT = 50;

  logic clk = 1'b0;
  logic rst;
  logic serial_in;

  uart_rx_buffered_if #(.FIFO_DEPTH(8)) rx_if ();

  uart_rx_buffered #(
    .CLOCK_FREQ(50_000_000),
    .BAUD_RATE (1_000_000),
    .FIFO_DEPTH(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .serial_in(serial_in),
    .rx       (rx_if)
  );

  always #10 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Monitor: everything observed on the falling edge, away from the active edge.
  int         valid_cycles = 0;
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  logic [7:0] rx_q [$];

  always @(negedge clk) begin
    if (!rst) begin
      if (rx_if.data_out_valid) valid_cycles++;
      if (rx_if.data_out_valid && rx_if.data_out_ready) rx_q.push_back(rx_if.data_out);
      if (rx_if.frame_err) fe_cnt++;
      if (rx_if.overrun)   ov_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic line(input logic v, input int n);
    serial_in = v;
    tick(n);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int stop_bits);
    line(1'b0, BIT);
    for (int i = 0; i < 8; i++) line(b[i], BIT);
    line(stop, BIT * stop_bits);
    serial_in = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         stop_bits;
    int         exp_bytes;
    logic [7:0] exp_byte;
    int         exp_fe;
  } vec_t;

  vec_t vecs [5];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int qb, vb, fb, ob;
    logic found;

    vecs[0] = '{8'h78, 1'b1, 1, 1, 8'h78, 0};
    vecs[1] = '{8'h00, 1'b1, 1, 1, 8'h00, 0};
    vecs[2] = '{8'hff, 1'b1, 1, 1, 8'hff, 0};
    vecs[3] = '{8'ha5, 1'b0, 2, 0, 8'h00, 1};
    vecs[4] = '{8'h31, 1'b1, 1, 1, 8'h31, 0};

    rst = 1'b1;
    serial_in = 1'b1;
    rx_if.data_out_ready = 1'b0;
    tick(5);
    check("reset valid",     32'(rx_if.data_out_valid), 32'd0);
    check("reset count",     32'(rx_if.fifo_count),     32'd0);
    check("reset frame_err", 32'(rx_if.frame_err),      32'd0);
    check("reset overrun",   32'(rx_if.overrun),        32'd0);
    rst = 1'b0;
    line(1'b1, 20);

    // Single frames with ready held high.
    rx_if.data_out_ready = 1'b1;
    foreach (vecs[k]) begin
      qb = rx_q.size(); vb = valid_cycles; fb = fe_cnt; ob = ov_cnt;
      send_frame(vecs[k].data, vecs[k].stop, vecs[k].stop_bits);
      line(1'b1, 60);
      check($sformatf("vec%0d bytes", k), 32'(rx_q.size() - qb), 32'(vecs[k].exp_bytes));
      if (vecs[k].exp_bytes == 1 && rx_q.size() > qb)
        check($sformatf("vec%0d data", k), 32'(rx_q[qb]), 32'(vecs[k].exp_byte));
      check($sformatf("vec%0d valid cycles", k), 32'(valid_cycles - vb), 32'(vecs[k].exp_bytes));
      check($sformatf("vec%0d frame_err", k), 32'(fe_cnt - fb), 32'(vecs[k].exp_fe));
      check($sformatf("vec%0d overrun", k), 32'(ov_cnt - ob), 32'd0);
      check($sformatf("vec%0d count", k), 32'(rx_if.fifo_count), 32'd0);
    end

    // Back-to-back frames buffered with ready low, then drained in order.
    rx_if.data_out_ready = 1'b0;
    send_frame(8'h78, 1'b1, 1);
    send_frame(8'h79, 1'b1, 1);
    send_frame(8'h7a, 1'b1, 1);
    send_frame(8'h0d, 1'b1, 1);
    line(1'b1, 60);
    check("b2b count", 32'(rx_if.fifo_count), 32'd4);
    qb = rx_q.size();
    rx_if.data_out_ready = 1'b1;
    tick(8);
    check("b2b drained", 32'(rx_q.size() - qb), 32'd4);
    if (rx_q.size() - qb == 4) begin
      check("b2b byte0", 32'(rx_q[qb]),     32'h78);
      check("b2b byte1", 32'(rx_q[qb + 1]), 32'h79);
      check("b2b byte2", 32'(rx_q[qb + 2]), 32'h7a);
      check("b2b byte3", 32'(rx_q[qb + 3]), 32'h0d);
    end
    check("b2b count empty", 32'(rx_if.fifo_count), 32'd0);

    // Short low glitch is rejected as a false start.
    vb = valid_cycles; fb = fe_cnt; ob = ov_cnt;
    line(1'b0, 10);
    line(1'b1, 100);
    check("glitch valid",     32'(valid_cycles - vb), 32'd0);
    check("glitch frame_err", 32'(fe_cnt - fb),       32'd0);
    check("glitch overrun",   32'(ov_cnt - ob),       32'd0);
    check("glitch state",     32'(dut.state),         32'(IDLE));

    // Nine bytes into an eight-entry FIFO: the ninth overruns.
    rx_if.data_out_ready = 1'b0;
    ob = ov_cnt;
    for (int i = 0; i < 9; i++) send_frame(8'(i), 1'b1, 1);
    line(1'b1, 60);
    check("ovr pulses", 32'(ov_cnt - ob), 32'd1);
    check("ovr count",  32'(rx_if.fifo_count), 32'd8);
    qb = rx_q.size();
    rx_if.data_out_ready = 1'b1;
    tick(12);
    check("ovr drained", 32'(rx_q.size() - qb), 32'd8);
    if (rx_q.size() - qb == 8)
      for (int i = 0; i < 8; i++)
        check($sformatf("ovr byte%0d", i), 32'(rx_q[qb + i]), 32'(i));

    // Full FIFO with a pop on the stop-sample cycle accepts the new byte.
    rx_if.data_out_ready = 1'b0;
    ob = ov_cnt;
    for (int i = 0; i < 8; i++) send_frame(8'(i), 1'b1, 1);
    line(1'b1, 20);
    check("full count", 32'(rx_if.fifo_count), 32'd8);
    found = 1'b0;
    fork
      send_frame(8'h08, 1'b1, 1);
      begin
        for (int i = 0; i < 1000 && !found; i++) begin
          @(posedge clk);
          #1;
          if (dut.state == STOP && 32'(dut.cnt) == BIT - 1) found = 1'b1;
        end
        if (found) begin
          rx_if.data_out_ready = 1'b1;
          @(posedge clk);
          #1;
          rx_if.data_out_ready = 1'b0;
        end
      end
    join
    check("full stop sample reached", 32'(found), 32'd1);
    line(1'b1, 20);
    check("full overrun", 32'(ov_cnt - ob), 32'd0);
    check("full count after", 32'(rx_if.fifo_count), 32'd8);
    qb = rx_q.size() - 1;
    rx_if.data_out_ready = 1'b1;
    tick(12);
    check("full drained", 32'(rx_q.size() - qb), 32'd9);
    if (rx_q.size() - qb == 9)
      for (int i = 0; i < 9; i++)
        check($sformatf("full byte%0d", i), 32'(rx_q[qb + i]), 32'(i));

    // Reset during data bit 4 with a byte already buffered.
    rx_if.data_out_ready = 1'b0;
    send_frame(8'h11, 1'b1, 1);
    line(1'b1, 20);
    check("pre-reset count", 32'(rx_if.fifo_count), 32'd1);
    begin
      logic [7:0] partial;
      partial = 8'h5a;
      line(1'b0, BIT);
      for (int i = 0; i < 4; i++) line(partial[i], BIT);
      line(partial[4], BIT / 2);
    end
    rst = 1'b1;
    serial_in = 1'b1;
    tick(3);
    check("midrst valid",     32'(rx_if.data_out_valid), 32'd0);
    check("midrst count",     32'(rx_if.fifo_count),     32'd0);
    check("midrst frame_err", 32'(rx_if.frame_err),      32'd0);
    check("midrst overrun",   32'(rx_if.overrun),        32'd0);
    rst = 1'b0;
    line(1'b1, BIT);
    qb = rx_q.size(); fb = fe_cnt;
    rx_if.data_out_ready = 1'b1;
    send_frame(8'h3e, 1'b1, 1);
    line(1'b1, 60);
    check("post-reset bytes", 32'(rx_q.size() - qb), 32'd1);
    if (rx_q.size() > qb) check("post-reset data", 32'(rx_q[qb]), 32'h3e);
    check("post-reset frame_err", 32'(fe_cnt - fb), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
